dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameters:
- DM_ADDRESS, default 9, memory byte-address width.
- DATA_W, default 32, data width.
- STARVE_MAX, default 4, maximum consecutive port-0 grants while port 1 waits.

REQ-002 The block SHALL have these ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rN_valid  in  1  request valid, N=0 (pipeline MEM stage) and N=1 (debug/DMA).
- rN_ready  out  1  request accepted this cycle.
- rN_we  in  1  1=store, 0=load.
- rN_addr  in  DM_ADDRESS  byte address.
- rN_wdata  in  DATA_W  store data.
- rN_funct3  in  3  access size/sign code (LB/LH/LW/LBU, SB/SH/SW).
- rspN_valid  out  1  one-cycle response strobe to port N.
- rsp_rdata  out  DATA_W  load data, shared by both ports.
- rsp_err  out  1  response carries an error.
- mem_MemRead  out  1  to data memory MemRead.
- mem_MemWrite  out  1  to data memory MemWrite.
- mem_a  out  DM_ADDRESS  to data memory a.
- mem_wd  out  DATA_W  to data memory wd.
- mem_Funct3  out  3  to data memory Funct3.
- mem_rd  in  DATA_W  from data memory rd.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-004 rN_ready SHALL be asserted only in IDLE or RESP, and only for the port granted that cycle; at most one rN_ready is high per cycle.
REQ-005 Arbitration SHALL be fixed priority to port 0, except that port 1 wins when starve_cnt == STARVE_MAX and r1_valid=1.
REQ-006 starve_cnt SHALL increment on each port-0 accept while r1_valid=1, clear on any port-1 accept or when r1_valid=0, and saturate at STARVE_MAX.
REQ-007 On accept (valid && ready), the block SHALL register we, addr, wdata, funct3 and port ID, then move to ACCESS next cycle; if the request is illegal (REQ-011), it SHALL move directly to RESP instead.
REQ-008 In ACCESS, mem_MemRead=~we and mem_MemWrite=we SHALL be driven from the registered request, with mem_a, mem_wd and mem_Funct3 equal to the registered fields; the block SHALL capture mem_rd at the end of ACCESS and go to RESP.
REQ-009 In all states other than ACCESS, mem_MemRead and mem_MemWrite SHALL be 0, and mem_a, mem_wd and mem_Funct3 SHALL hold their last values.
REQ-010 In RESP, the block SHALL assert rspN_valid for the registered port for exactly one cycle, with the following values:
- rsp_rdata = captured data for loads; 0 for stores and for errors.
- rsp_err = 1 for an illegal request, otherwise 0.
REQ-011 A request SHALL be illegal, and never reach memory, in any of these cases:
- load funct3 not in {000,001,010,100};
- store funct3 not in {000,001,010};
- LW/SW with addr[1:0]!=0;
- LH/SH with addr[0]=1.
REQ-012 From RESP, the block SHALL go to ACCESS (or RESP if illegal) when a new request is accepted that cycle, otherwise to IDLE.
- Throughput: one legal access per 2 cycles.
- Latency: accept-to-response is 2 cycles.
REQ-013 A requester SHALL hold rN_valid and all rN_* fields stable until rN_ready; the block SHALL not sample unaccepted requests.
REQ-014 With both ports valid in the same cycle, exactly one SHALL be accepted per REQ-005; the other stays pending with rN_ready=0.

Reset
REQ-015 rst_n=0 SHALL asynchronously force all of the following, and any in-flight request SHALL be dropped with no response:
- state=IDLE, starve_cnt=0;
- all rN_ready, rspN_valid, rsp_err, mem_MemRead, mem_MemWrite = 0;
- rsp_rdata, mem_a, mem_wd, mem_Funct3 = 0.
REQ-016 After rst_n deasserts, the first accept SHALL be possible in the first cycle in IDLE.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Single load: r0 LW addr 0x010 with mem_rd=0xDEADBEEF → r0_ready cycle T; mem_MemRead=1 at T+1; rsp0_valid=1, rsp_rdata=0xDEADBEEF, rsp_err=0 at T+2.
- Store: r1 SW addr 0x024 wdata 0x12345678 → mem_MemWrite=1, mem_a=0x024, mem_wd=0x12345678 for exactly one cycle; rsp1_valid with rsp_rdata=0.
- Contention: both ports valid every cycle, STARVE_MAX=4 → port-0 grant sequence 0,0,0,0,1,0,0,0,0,1; no cycle with both rN_ready=1.
- Misaligned: r0 LH addr 0x003 → mem_MemRead/mem_MemWrite stay 0; rsp0_valid with rsp_err=1 one cycle after accept.
- Back-to-back: r0 issues LW@0x000 then LB@0x004 continuously valid → second accept in the RESP cycle of the first; responses 2 cycles apart.
- Reset mid-operation: rst_n low during ACCESS → outputs 0 immediately; no rsp*_valid after release; next request served normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter.
// Port 0 is the pipeline MEM stage and port 1 is the debug/DMA requester.
// Port 0 has priority, and a starvation counter guarantees that port 1 is
// eventually granted. A legal access takes ACCESS then RESP. An illegal
// access never reaches memory and is answered with an error one cycle
// after it is accepted.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [DM_ADDRESS-1:0] r0_addr,
  input  logic [DATA_W-1:0]     r0_wdata,
  input  logic [2:0]            r0_funct3,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [DM_ADDRESS-1:0] r1_addr,
  input  logic [DATA_W-1:0]     r1_wdata,
  input  logic [2:0]            r1_funct3,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_MemRead,
  output logic                  mem_MemWrite,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_Funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state, state_nx;
  logic [SW-1:0]           starve_cnt;
  logic                    we_q, port_q, err_q;
  logic [DATA_W-1:0]       rdata_q;
  logic [DM_ADDRESS-1:0]   a_q;
  logic [DATA_W-1:0]       wd_q;
  logic [2:0]              f3_q;

  logic                    can_accept, pick1, accept;
  logic                    sel_we, sel_legal;
  logic [DM_ADDRESS-1:0]   sel_addr;
  logic [DATA_W-1:0]       sel_wdata;
  logic [2:0]              sel_f3;

  // Check the size code and the natural alignment. LBU is load-only.
  function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                    input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~lo[0];
      3'b010:  ok = (lo == 2'b00);
      3'b100:  ok = ~we;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Grant selection. Port 1 wins only when port 0 is idle or port 1 is starved.
  assign can_accept = rst_n && (state == IDLE || state == RESP);
  assign pick1      = r1_valid && (!r0_valid || starve_cnt == SW'(STARVE_MAX));
  assign accept     = r0_ready | r1_ready;

  assign sel_we    = r1_ready ? r1_we     : r0_we;
  assign sel_addr  = r1_ready ? r1_addr   : r0_addr;
  assign sel_wdata = r1_ready ? r1_wdata  : r0_wdata;
  assign sel_f3    = r1_ready ? r1_funct3 : r0_funct3;
  assign sel_legal = is_legal(sel_we, sel_f3, sel_addr[1:0]);

  // The memory address and data hold their values outside ACCESS, so they come straight from their registers.
  assign mem_a      = a_q;
  assign mem_wd     = wd_q;
  assign mem_Funct3 = f3_q;

  // Next-state logic and per-state outputs.
  always_comb begin
    // NOTE: every output gets a default first so that no path through the case infers a latch.
    state_nx     = state;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
    mem_MemRead  = 1'b0;
    mem_MemWrite = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp_rdata    = '0;
    rsp_err      = 1'b0;
    if (can_accept) begin
      r0_ready = r0_valid & ~pick1;
      r1_ready = pick1;
    end
    case (state)
      IDLE: begin
        if (r0_ready || r1_ready) state_nx = sel_legal ? ACCESS : RESP;
      end
      ACCESS: begin
        mem_MemRead  = ~we_q;
        mem_MemWrite = we_q;
        state_nx     = RESP;
      end
      RESP: begin
        rsp0_valid = ~port_q;
        rsp1_valid = port_q;
        rsp_err    = err_q;
        rsp_rdata  = (we_q || err_q) ? '0 : rdata_q;
        if (r0_ready || r1_ready) state_nx = sel_legal ? ACCESS : RESP;
        else                      state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Capture the accepted request and the read data at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      a_q     <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
    end else begin
      if (accept) begin
        we_q   <= sel_we;
        port_q <= r1_ready;
        err_q  <= ~sel_legal;
        if (sel_legal) begin
          a_q  <= sel_addr;
          wd_q <= sel_wdata;
          f3_q <= sel_f3;
        end
      end
      if (state == ACCESS) rdata_q <= mem_rd;
    end
  end

  // Starvation counter. It counts port-0 grants taken while port 1 waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             starve_cnt <= '0;
    else if (r1_ready || !r1_valid)         starve_cnt <= '0;
    else if (r0_ready && starve_cnt != SW'(STARVE_MAX))
                                            starve_cnt <= starve_cnt + SW'(1);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// A transaction-level model predicts ready, memory and response outputs
// every cycle. Directed scenarios are followed by randomized traffic.
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_valid, r0_ready, r0_we, r1_valid, r1_ready, r1_we;
  logic [AW-1:0] r0_addr, r1_addr, mem_a;
  logic [DW-1:0] r0_wdata, r1_wdata, rsp_rdata, mem_wd, mem_rd;
  logic [2:0]    r0_funct3, r1_funct3, mem_Funct3;
  logic          rsp0_valid, rsp1_valid, rsp_err, mem_MemRead, mem_MemWrite;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_funct3(r0_funct3),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_funct3(r1_funct3),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_Funct3(mem_Funct3), .mem_rd(mem_rd)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    f3;
  } req_t;

  req_t q0[$], q1[$];
  req_t cur0, cur1;
  bit   shown0, shown1;
  bit   rand_mode;
  logic [DW-1:0] mem_fixed;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Transaction-level model state.
  bit            have_txn;
  int            t_port, t_acc, resp_cycle, starve;
  req_t          t_req;
  bit            t_legal;
  logic [DW-1:0] t_rd;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_wd;
  logic [2:0]    m_f3;

  int grants[$], acc_at[$], rsp_at[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal_m(input req_t r);
    int size;
    if (r.we && r.f3 > 3'd2) return 1'b0;
    if (!r.we && !(r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4})) return 1'b0;
    size = 1 << r.f3[1:0];
    return (int'(r.addr) % size) == 0;
  endfunction

  function automatic req_t mk(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [2:0] f3);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.f3 = f3;
    return r;
  endfunction

  task automatic model_reset();
    have_txn = 1'b0; resp_cycle = 0; starve = 0;
    m_a = '0; m_wd = '0; m_f3 = '0;
    shown0 = 1'b0; shown1 = 1'b0;
    q0.delete(); q1.delete();
  endtask

  // Predict this cycle's outputs, compare them, then advance the model.
  task automatic model_check();
    bit free, p1, e0, e1, macc, mrsp;
    req_t r;
    free = cyc >= resp_cycle;
    p1   = r1_valid && (!r0_valid || starve >= SM);
    e0   = free && r0_valid && !p1;
    e1   = free && p1;
    macc = have_txn && t_legal && cyc == t_acc + 1;
    mrsp = have_txn && cyc == resp_cycle;
    if (macc) t_rd = mem_rd;
    check("r0_ready", r0_ready, e0);
    check("r1_ready", r1_ready, e1);
    check("mem_MemRead", mem_MemRead, macc && !t_req.we);
    check("mem_MemWrite", mem_MemWrite, macc && t_req.we);
    check("mem_a", mem_a, m_a);
    check("mem_wd", mem_wd, m_wd);
    check("mem_Funct3", mem_Funct3, m_f3);
    check("rsp0_valid", rsp0_valid, mrsp && t_port == 0);
    check("rsp1_valid", rsp1_valid, mrsp && t_port == 1);
    if (mrsp) begin
      check("rsp_rdata", rsp_rdata, (t_legal && !t_req.we) ? t_rd : '0);
      check("rsp_err", rsp_err, !t_legal);
    end
    if (e0 || e1) begin
      r          = e1 ? cur1 : cur0;
      have_txn   = 1'b1;
      t_port     = e1 ? 1 : 0;
      t_req      = r;
      t_legal    = legal_m(r);
      t_acc      = cyc;
      resp_cycle = cyc + (t_legal ? 2 : 1);
      if (t_legal) begin
        m_a = r.addr; m_wd = r.wdata; m_f3 = r.f3;
      end
    end
    if (e1 || !r1_valid) starve = 0;
    else if (e0)         starve = (starve + 1 > SM) ? SM : starve + 1;
  endtask

  // One clock cycle. Drive after the rising edge, then check and handshake at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!shown0 && q0.size() > 0 && (!rand_mode || $urandom_range(0, 99) < 60)) shown0 = 1'b1;
    if (!shown1 && q1.size() > 0 && (!rand_mode || $urandom_range(0, 99) < 60)) shown1 = 1'b1;
    cur0 = shown0 ? q0[0] : mk(1'($urandom), AW'($urandom), $urandom, 3'($urandom));
    cur1 = shown1 ? q1[0] : mk(1'($urandom), AW'($urandom), $urandom, 3'($urandom));
    r0_valid = shown0; r0_we = cur0.we; r0_addr = cur0.addr; r0_wdata = cur0.wdata; r0_funct3 = cur0.f3;
    r1_valid = shown1; r1_we = cur1.we; r1_addr = cur1.addr; r1_wdata = cur1.wdata; r1_funct3 = cur1.f3;
    mem_rd = rand_mode ? $urandom : mem_fixed;
    @(negedge clk);
    model_check();
    check("single_ready", r0_ready & r1_ready, 1'b0);
    if (r0_ready && shown0) begin
      void'(q0.pop_front()); shown0 = 1'b0; grants.push_back(0); acc_at.push_back(cyc);
    end
    if (r1_ready && shown1) begin
      void'(q1.pop_front()); shown1 = 1'b0; grants.push_back(1); acc_at.push_back(cyc);
    end
    if (rsp0_valid || rsp1_valid) rsp_at.push_back(cyc);
  endtask

  task automatic clear_logs();
    grants.delete(); acc_at.delete(); rsp_at.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r0_ready"}, r0_ready, 1'b0);
    check({tag, "_r1_ready"}, r1_ready, 1'b0);
    check({tag, "_rsp0"}, rsp0_valid, 1'b0);
    check({tag, "_rsp1"}, rsp1_valid, 1'b0);
    check({tag, "_err"}, rsp_err, 1'b0);
    check({tag, "_rd"}, mem_MemRead, 1'b0);
    check({tag, "_wr"}, mem_MemWrite, 1'b0);
    check({tag, "_rdata"}, rsp_rdata, '0);
    check({tag, "_a"}, mem_a, '0);
    check({tag, "_wd"}, mem_wd, '0);
    check({tag, "_f3"}, mem_Funct3, '0);
  endtask

  int exp_g[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int n_wr, n_rsp, guard;

  initial begin
    rand_mode = 1'b0; mem_fixed = '0; mem_rd = '0;
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; r0_funct3 = 3'b010;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_funct3 = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    r0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single load.
    clear_logs();
    mem_fixed = 32'hDEADBEEF;
    q0.push_back(mk(1'b0, 9'h010, '0, 3'b010));
    step();
    check("ld_accept", r0_ready, 1'b1);
    step();
    check("ld_memread", mem_MemRead, 1'b1);
    check("ld_mem_a", mem_a, 9'h010);
    step();
    check("ld_rsp0", rsp0_valid, 1'b1);
    check("ld_rdata", rsp_rdata, 32'hDEADBEEF);
    check("ld_err", rsp_err, 1'b0);
    step();

    // Store from port 1.
    q1.push_back(mk(1'b1, 9'h024, 32'h12345678, 3'b010));
    n_wr = 0; n_rsp = 0;
    repeat (5) begin
      step();
      if (mem_MemWrite) begin
        n_wr++;
        check("st_mem_a", mem_a, 9'h024);
        check("st_mem_wd", mem_wd, 32'h12345678);
      end
      if (rsp1_valid) begin
        n_rsp++;
        check("st_rdata", rsp_rdata, '0);
      end
    end
    check("st_write_cycles", n_wr, 1);
    check("st_rsp_count", n_rsp, 1);

    // Contention between both ports.
    clear_logs();
    for (int i = 0; i < 12; i++) q0.push_back(mk(1'b0, AW'(i * 4), '0, 3'b010));
    for (int i = 0; i < 4; i++)  q1.push_back(mk(1'b0, AW'(i * 4 + 64), '0, 3'b010));
    guard = 0;
    while (grants.size() < 10 && guard < 60) begin step(); guard++; end
    check("cont_grant_count", grants.size() >= 10, 1'b1);
    for (int i = 0; i < 10 && i < grants.size(); i++) check($sformatf("cont_grant%0d", i), grants[i], exp_g[i]);
    guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 80) begin step(); guard++; end
    check("cont_drained", q0.size() + q1.size(), 0);
    repeat (3) step();

    // Misaligned halfword load.
    q0.push_back(mk(1'b0, 9'h003, '0, 3'b001));
    step();
    check("mis_accept", r0_ready, 1'b1);
    check("mis_memread0", mem_MemRead, 1'b0);
    step();
    check("mis_rsp0", rsp0_valid, 1'b1);
    check("mis_err", rsp_err, 1'b1);
    check("mis_memread1", mem_MemRead, 1'b0);
    check("mis_memwrite1", mem_MemWrite, 1'b0);
    step();

    // Back-to-back loads on port 0.
    clear_logs();
    q0.push_back(mk(1'b0, 9'h000, '0, 3'b010));
    q0.push_back(mk(1'b0, 9'h004, '0, 3'b000));
    repeat (6) step();
    check("b2b_accepts", acc_at.size(), 2);
    check("b2b_rsps", rsp_at.size(), 2);
    if (acc_at.size() == 2 && rsp_at.size() == 2) begin
      check("b2b_acc_in_resp", acc_at[1] - rsp_at[0], 0);
      check("b2b_rsp_gap", rsp_at[1] - rsp_at[0], 2);
    end

    // Reset while an access is in flight.
    q0.push_back(mk(1'b0, 9'h040, '0, 3'b010));
    step();
    step();
    check("rst_in_access", mem_MemRead, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    model_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    clear_logs();
    repeat (3) step();
    check("rst_no_rsp", rsp_at.size(), 0);
    mem_fixed = 32'hA5A5_0F0F;
    q0.push_back(mk(1'b0, 9'h044, '0, 3'b010));
    repeat (4) step();
    check("rst_served", rsp_at.size(), 1);

    // Randomized traffic.
    rand_mode = 1'b1;
    repeat (3000) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0)
        q0.push_back(mk(1'($urandom), AW'($urandom), $urandom, 3'($urandom)));
      if (q1.size() == 0 && $urandom_range(0, 3) == 0)
        q1.push_back(mk(1'($urandom), AW'($urandom), $urandom, 3'($urandom)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
